// File: rtl/bootcode_postcode_capture_pkg.sv
// +----------------------------------------------------------------------------+
// | bootcode_capture_pkg                                                       |
// | Shared types and constants for the bootcode postcode capture block.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package bootcode_capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    HALT = 2'd2
  } state_e;

  // Codes whose top byte is at or above this value are treated as fatal errors.
  localparam logic [7:0] POST_ERR_THRESH = 8'hF0;

  localparam int STAT_OVF_LSB   = 24;
  localparam int STAT_DUP_LSB   = 16;
  localparam int STAT_LVL_LSB   = 8;
  localparam int STAT_FULL_BIT  = 2;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_ERR_BIT   = 0;

endpackage

`default_nettype wire

// File: rtl/bootcode_postcode_capture_if.sv
// +----------------------------------------------------------------------------+
// | bootcode_postcode_capture_if                                               |
// | Register bus and postcode output bundle for the capture block.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface bootcode_postcode_capture_if #(
  parameter int AW = 16
);
  logic          BusWrEn;
  logic [AW-1:0] BusAddr;
  logic [31:0]   BusWrData;
  logic          BusRdEn;
  logic [31:0]   BusRdData;
  logic [31:0]   PostCode;
  logic          PostCodeStrobe;
  logic          PostErr;
  logic          Halt;

  modport master (
    output BusWrEn, BusAddr, BusWrData, BusRdEn,
    input  BusRdData, PostCode, PostCodeStrobe, PostErr, Halt
  );

  modport slave (
    input  BusWrEn, BusAddr, BusWrData, BusRdEn,
    output BusRdData, PostCode, PostCodeStrobe, PostErr, Halt
  );
endinterface

`default_nettype wire

// File: rtl/bootcode_postcode_capture_fifo.sv
// +----------------------------------------------------------------------------+
// | bootcode_sync_fifo                                                         |
// | Single-clock FIFO with a combinational head and an occupancy count.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module bootcode_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     i_push,
  input  wire logic [WIDTH-1:0]         i_wdata,
  input  wire logic                     i_pop,
  output logic      [WIDTH-1:0]         o_head,
  output logic      [$clog2(DEPTH):0]   o_level,
  output logic                          o_full,
  output logic                          o_empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_push) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
    if (i_pop)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // A push into a full FIFO is only issued alongside a pop, so it reuses the slot being read.
  always_ff @(posedge clk) begin
    if (i_push) mem_q[wr_ptr_q[PW-1:0]] <= i_wdata;
  end

  assign o_head  = mem_q[rd_ptr_q[PW-1:0]];
  assign o_level = wr_ptr_q - rd_ptr_q;
  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

endmodule

`default_nettype wire

// File: rtl/bootcode_postcode_capture.sv
// +----------------------------------------------------------------------------+
// | bootcode_postcode_capture                                                  |
// | Buffers POST writes and replays them with a minimum hold, halting on error.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module bootcode_postcode_capture
  import bootcode_capture_pkg::*;
#(
  parameter int            DEPTH       = 16,
  parameter int            HOLD_CYCLES = 8,
  parameter int            AW          = 16,
  parameter logic [AW-1:0] POST_ADDR   = 16'h0080,
  parameter logic [AW-1:0] CTRL_ADDR   = 16'h0084,
  parameter logic [AW-1:0] STAT_ADDR   = 16'h0088
) (
  input wire logic                  Clk,
  input wire logic                  Reset,
  bootcode_postcode_capture_if.slave bus
);
  localparam int             LW        = $clog2(DEPTH) + 1;
  localparam int             HCW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0] HOLD_INIT = HCW'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [31:0]      post_code_q, post_code_d;
  logic             strobe_q, strobe_d;
  logic             post_err_q, post_err_d;
  logic [31:0]      last_push_q, last_push_d;
  logic [7:0]       ovf_cnt_q, ovf_cnt_d;
  logic [7:0]       dup_cnt_q, dup_cnt_d;
  logic [31:0]      rd_data_q, rd_data_d;

  logic [31:0]      fifo_head;
  logic [LW-1:0]    fifo_level;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic             wr_post, wr_ctrl, is_dup, is_ovf, clr_err, clr_cnt;
  logic [31:0]      stat_word;

  bootcode_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (Clk),
    .rst     (Reset),
    .i_push  (fifo_push),
    .i_wdata (bus.BusWrData),
    .i_pop   (fifo_pop),
    .o_head  (fifo_head),
    .o_level (fifo_level),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Duplicate check takes priority; a full FIFO only drops when nothing leaves this cycle.
  always_comb begin
    wr_post   = bus.BusWrEn && (bus.BusAddr == POST_ADDR);
    wr_ctrl   = bus.BusWrEn && (bus.BusAddr == CTRL_ADDR);
    clr_err   = wr_ctrl && bus.BusWrData[0];
    clr_cnt   = wr_ctrl && bus.BusWrData[1];
    fifo_pop  = (state_q == IDLE) && !fifo_empty;
    is_dup    = wr_post && (bus.BusWrData == last_push_q);
    is_ovf    = wr_post && !is_dup && fifo_full && !fifo_pop;
    fifo_push = wr_post && !is_dup && !is_ovf;
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    post_code_d = post_code_q;
    strobe_d    = 1'b0;
    post_err_d  = post_err_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          post_code_d = fifo_head;
          strobe_d    = 1'b1;
          hold_cnt_d  = HOLD_INIT;
          state_d     = (fifo_head[31:24] >= POST_ERR_THRESH) ? HALT : HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt_q == '0) state_d = IDLE;
        else                  hold_cnt_d = hold_cnt_q - HCW'(1);
      end
      HALT: begin
        post_err_d = 1'b1;
        if (clr_err) begin
          post_err_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_push_d = fifo_push ? bus.BusWrData : last_push_q;
    ovf_cnt_d   = ovf_cnt_q;
    dup_cnt_d   = dup_cnt_q;
    if (is_ovf && (ovf_cnt_q != 8'hFF)) ovf_cnt_d = ovf_cnt_q + 8'd1;
    if (is_dup && (dup_cnt_q != 8'hFF)) dup_cnt_d = dup_cnt_q + 8'd1;
    if (clr_cnt) begin
      ovf_cnt_d = '0;
      dup_cnt_d = '0;
    end

    stat_word                              = '0;
    stat_word[STAT_OVF_LSB +: 8]           = ovf_cnt_q;
    stat_word[STAT_DUP_LSB +: 8]           = dup_cnt_q;
    stat_word[STAT_LVL_LSB +: 8]           = 8'(fifo_level);
    stat_word[STAT_FULL_BIT]               = fifo_full;
    stat_word[STAT_EMPTY_BIT]              = fifo_empty;
    stat_word[STAT_ERR_BIT]                = post_err_q;

    rd_data_d = rd_data_q;
    if (bus.BusRdEn) rd_data_d = (bus.BusAddr == STAT_ADDR) ? stat_word : '0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      post_code_q <= '0;
      strobe_q    <= 1'b0;
      post_err_q  <= 1'b0;
      last_push_q <= '0;
      ovf_cnt_q   <= '0;
      dup_cnt_q   <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      post_code_q <= post_code_d;
      strobe_q    <= strobe_d;
      post_err_q  <= post_err_d;
      last_push_q <= last_push_d;
      ovf_cnt_q   <= ovf_cnt_d;
      dup_cnt_q   <= dup_cnt_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign bus.PostCode       = post_code_q;
  assign bus.PostCodeStrobe = strobe_q;
  assign bus.PostErr        = post_err_q;
  assign bus.Halt           = post_err_q;
  assign bus.BusRdData      = rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_bootcode_postcode_capture.sv
// +----------------------------------------------------------------------------+
// | tb_bootcode_postcode_capture                                               |
// | Directed and random stimulus against a queue-based reference model.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bootcode_postcode_capture;
  localparam int          DEPTH  = 16;
  localparam int          HOLD   = 8;
  localparam int          AW     = 16;
  localparam logic [15:0] POST_A = 16'h0080;
  localparam logic [15:0] CTRL_A = 16'h0084;
  localparam logic [15:0] STAT_A = 16'h0088;

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  bootcode_postcode_capture_if #(.AW(AW)) bus_if ();

  bootcode_postcode_capture #(
    .DEPTH       (DEPTH),
    .HOLD_CYCLES (HOLD),
    .AW          (AW),
    .POST_ADDR   (POST_A),
    .CTRL_ADDR   (CTRL_A),
    .STAT_ADDR   (STAT_A)
  ) u_dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of pending codes plus the earliest cycle a new code may go out.
  logic [31:0] mq[$];
  logic [31:0] m_last, m_code, m_rd;
  logic [7:0]  m_ovf, m_dup;
  bit          m_strobe, m_err, m_halted;
  int          m_earliest;

  int          s_cyc[$];
  logic [31:0] s_code[$];

  task automatic model_edge();
    bit          halted_pre, full_pre, pop, wr_post, wr_ctrl;
    logic [31:0] stat, d;
    if (rst) begin
      mq.delete();
      m_last = '0; m_code = '0; m_rd = '0; m_ovf = '0; m_dup = '0;
      m_strobe = 0; m_err = 0; m_halted = 0; m_earliest = 0;
      return;
    end
    d          = bus_if.BusWrData;
    halted_pre = m_halted;
    full_pre   = (mq.size() == DEPTH);
    stat       = {m_ovf, m_dup, 8'(mq.size()), 5'b0, full_pre, mq.size() == 0, m_err};
    if (bus_if.BusRdEn) m_rd = (bus_if.BusAddr == STAT_A) ? stat : 32'h0;
    wr_post = bus_if.BusWrEn && (bus_if.BusAddr == POST_A);
    wr_ctrl = bus_if.BusWrEn && (bus_if.BusAddr == CTRL_A);
    pop     = !halted_pre && (mq.size() > 0) && (cyc >= m_earliest);
    m_strobe = pop;
    if (pop) begin
      m_code     = mq.pop_front();
      m_earliest = cyc + HOLD + 1;
      if (m_code[31:24] >= 8'hF0) m_halted = 1;
    end
    if (halted_pre) begin
      if (wr_ctrl && d[0]) begin
        m_halted = 0; m_err = 0; m_earliest = cyc + 1;
      end else begin
        m_err = 1;
      end
    end
    if (wr_post) begin
      if (d == m_last) begin
        if (m_dup != 8'hFF) m_dup++;
      end else if (full_pre && !pop) begin
        if (m_ovf != 8'hFF) m_ovf++;
      end else begin
        mq.push_back(d);
        m_last = d;
      end
    end
    if (wr_ctrl && d[1]) begin
      m_ovf = '0; m_dup = '0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("postcode", bus_if.PostCode, m_code);
    chk("strobe",   32'(bus_if.PostCodeStrobe), 32'(m_strobe));
    chk("posterr",  32'(bus_if.PostErr), 32'(m_err));
    chk("halt",     32'(bus_if.Halt), 32'(m_err));
    chk("rddata",   bus_if.BusRdData, m_rd);
    if (bus_if.PostCodeStrobe === 1'b1) begin
      s_cyc.push_back(cyc);
      s_code.push_back(bus_if.PostCode);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    cyc++;
    #1;
    check_all();
  endtask

  task automatic drive(input bit we, input logic [15:0] a, input logic [31:0] d, input bit re);
    bus_if.BusWrEn   = we;
    bus_if.BusAddr   = a;
    bus_if.BusWrData = d;
    bus_if.BusRdEn   = re;
    tick();
    bus_if.BusWrEn   = 1'b0;
    bus_if.BusRdEn   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int w_cyc;
    rst = 1'b1;
    bus_if.BusWrEn = 1'b0; bus_if.BusRdEn = 1'b0;
    bus_if.BusAddr = '0;   bus_if.BusWrData = '0;
    idle(2);
    rst = 1'b0;
    chk("reset_postcode", bus_if.PostCode, 32'h0);
    chk("reset_err", 32'(bus_if.PostErr), 32'h0);

    // 1: three back-to-back codes, latency 2 and spacing HOLD+1
    s_cyc.delete(); s_code.delete();
    w_cyc = cyc;
    drive(1, POST_A, 32'd1, 0);
    drive(1, POST_A, 32'd2, 0);
    drive(1, POST_A, 32'd3, 0);
    idle(30);
    chk("t1_nstrobe", 32'(s_cyc.size()), 32'd3);
    if (s_cyc.size() == 3) begin
      chk("t1_latency", 32'(s_cyc[0] - w_cyc), 32'd2);
      chk("t1_space01", 32'(s_cyc[1] - s_cyc[0]), 32'(HOLD + 1));
      chk("t1_space12", 32'(s_cyc[2] - s_cyc[1]), 32'(HOLD + 1));
      for (int i = 0; i < 3; i++) chk("t1_code", s_code[i], 32'(i + 1));
    end

    // 2: duplicates are filtered and counted
    s_cyc.delete(); s_code.delete();
    drive(1, POST_A, 32'd5, 0);
    drive(1, POST_A, 32'd5, 0);
    drive(1, POST_A, 32'd5, 0);
    idle(12);
    chk("t2_nstrobe", 32'(s_cyc.size()), 32'd1);
    drive(0, STAT_A, 32'h0, 1);
    chk("t2_dupcnt", 32'(bus_if.BusRdData[23:16]), 32'd2);

    // 3: overflow while halted, then ordered replay and counter clear
    drive(1, CTRL_A, 32'h2, 0);
    drive(1, POST_A, 32'hF000_0000, 0);
    idle(3);
    chk("t3_halted", 32'(bus_if.Halt), 32'd1);
    for (int i = 0; i < 20; i++) drive(1, POST_A, 32'h100 + 32'(i), 0);
    drive(0, STAT_A, 32'h0, 1);
    chk("t3_stat", bus_if.BusRdData, 32'h0400_1005);
    s_cyc.delete(); s_code.delete();
    drive(1, CTRL_A, 32'h1, 0);
    idle(DEPTH * (HOLD + 1) + 5);
    chk("t3_nreplay", 32'(s_code.size()), 32'(DEPTH));
    if (s_code.size() == DEPTH)
      for (int i = 0; i < DEPTH; i++) chk("t3_order", s_code[i], 32'h100 + 32'(i));
    drive(1, CTRL_A, 32'h2, 0);
    drive(0, STAT_A, 32'h0, 1);
    chk("t3_cntclr", 32'(bus_if.BusRdData[31:16]), 32'h0);

    // 4: error code halts replay until cleared
    idle(12);
    s_cyc.delete(); s_code.delete();
    drive(1, POST_A, 32'hF100_0001, 0);
    idle(3);
    chk("t4_code", bus_if.PostCode, 32'hF100_0001);
    chk("t4_err", 32'(bus_if.PostErr), 32'd1);
    drive(1, POST_A, 32'hA, 0);
    drive(1, POST_A, 32'hB, 0);
    idle(20);
    chk("t4_nostrobe", 32'(s_cyc.size()), 32'd1);
    drive(1, CTRL_A, 32'h1, 0);
    idle(3);
    chk("t4_resume", bus_if.PostCode, 32'hA);
    chk("t4_errclr", 32'(bus_if.PostErr), 32'd0);

    // 5: reset mid-hold with entries queued
    idle(20);
    for (int i = 0; i < 4; i++) drive(1, POST_A, 32'h11 + 32'(i), 0);
    idle(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_code", bus_if.PostCode, 32'h0);
    s_cyc.delete(); s_code.delete();
    idle(20);
    chk("t5_nostrobe", 32'(s_cyc.size()), 32'd0);
    drive(0, STAT_A, 32'h0, 1);
    chk("t5_stat", bus_if.BusRdData, 32'h0000_0002);

    // 6: status read timing around a single push
    drive(1, POST_A, 32'd9, 0);
    drive(0, STAT_A, 32'h0, 1);
    chk("t6_lvl1", bus_if.BusRdData, 32'h0000_0100);
    drive(0, STAT_A, 32'h0, 1);
    chk("t6_lvl0", bus_if.BusRdData, 32'h0000_0002);
    drive(0, POST_A, 32'h0, 1);
    chk("t6_otheraddr", bus_if.BusRdData, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int          r, r2;
      logic [31:0] code;
      logic [15:0] ra;
      r  = $urandom_range(0, 99);
      r2 = $urandom_range(0, 19);
      code = (r2 == 0) ? (32'hF500_0000 | 32'($urandom_range(0, 3))) : 32'(r2 % 6);
      case ($urandom_range(0, 3))
        0:       ra = STAT_A;
        1:       ra = POST_A;
        2:       ra = CTRL_A;
        default: ra = 16'h1234;
      endcase
      if (r < 35)      drive(1, POST_A, code, $urandom_range(0, 3) == 0);
      else if (r < 42) drive(1, CTRL_A, 32'($urandom_range(0, 3)), 0);
      else if (r < 65) drive(0, ra, 32'h0, 1);
      else             tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
